// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared state encoding and IEEE-754 single-precision field helpers
//
// Purpose : common types and field positions for the fp multiply scheduler.
// Contents: state_t (IDLE/ISSUE/WAIT/RESP), exponent/sign bit positions,
//           is_zero_exp() which flags zero and denormal operands.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int SIGN_BIT = 31;

  // Zero and denormal operands both have an all-zero exponent field.
  function automatic logic is_zero_exp(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB] == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : picks the first asserted request after last_grant, wrapping modulo N.
// Ports   : req        in  N     request vector
//           last_grant in  IDW   index granted most recently
//           en         in  1     when low, no grant is issued
//           grant      out N     one-hot grant (zero when none)
//           grant_idx  out IDW   index of the granted request
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan last_grant+1 .. last_grant+N so the previous winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_grant) + k) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// rtl/fp_mul_sched.sv - round-robin scheduler sharing one multi-cycle fp32 multiply engine
//
// Purpose : accepts operand pairs from NUM_REQ requesters, runs them one at a time
//           through an external start/done multiplier and returns id-tagged results.
//           Zero/denormal operands bypass the engine; a silent engine times out.
// Ports   : clk, rst (sync, active-high)
//           req_valid/req_ready/req_a/req_b  per-requester operand handshake
//           rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err  result handshake
//           eng_start/eng_a/eng_b/eng_done/eng_result    engine interface
//           busy  high whenever a transaction is outstanding
module fp_mul_sched
  import fp_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic [31:0]           eng_a,
  output logic [31:0]           eng_b,
  input  logic                  eng_done,
  input  logic [31:0]           eng_result,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic               bypass;
  logic [CNT_W-1:0]   cnt_inc;

  // Grants are only offered in IDLE and never while reset is held.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .en         (state_q == IDLE && !rst),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign accept  = |(grant & req_valid);
  assign bypass  = is_zero_exp(a_q) || is_zero_exp(b_q);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = grant_idx;
          a_d     = req_a[32*grant_idx +: 32];
          b_d     = req_b[32*grant_idx +: 32];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bypass) begin
          data_d  = {a_q[SIGN_BIT] ^ b_q[SIGN_BIT], 31'b0};
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // The limit is tested on the incremented count so the error response
        // appears exactly TIMEOUT cycles after eng_start; done still wins a tie.
        if (eng_done) begin
          data_d  = eng_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = grant;
    rsp_valid = (state_q == RESP);
    eng_start = (state_q == ISSUE) && !bypass;
    busy      = (state_q != IDLE);
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign eng_a    = a_q;
  assign eng_b    = b_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb/tb_fp_mul_sched.sv - self-checking bench for fp_mul_sched with a transaction-level model
module tb_fp_mul_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  eng_start;
  logic [31:0]           eng_a, eng_b;
  logic                  eng_done;
  logic [31:0]           eng_result;
  logic                  busy;

  fp_mul_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Truncating fp32 multiply for normal operands whose product stays in range.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), m};
  endfunction

  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (last + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    if ($urandom_range(0, 9) == 0) e = 8'd0;
    else e = 8'($urandom_range(64, 190));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Model state and event logs
  int          eng_k = 25;
  int          acc_k = 0;
  bit          m_busy = 0;
  int          m_last = NUM_REQ - 1;
  int          m_id = 0, m_start = 0, m_rsp = 0;
  bit          m_byp = 0, m_err = 0;
  logic [31:0] m_a = 0, m_b = 0, m_data = 0;
  int          acc_cnt = 0, hs_cnt = 0, start_cnt = 0;
  int          last_acc_cyc = 0, last_acc_id = 0, hs_cyc = 0;
  int          acc_lat = 0;
  logic [31:0] acc_data = 0;
  bit          acc_err = 0;
  int          acc_log[$];

  // Compare process: checks every DUT output against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 0;
        m_last = NUM_REQ - 1;
      end else begin
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        chk("busy", 32'(busy), 32'(m_busy));
        if (!m_busy) begin
          int g;
          logic [NUM_REQ-1:0] er;
          g  = exp_grant(req_valid, m_last);
          er = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
          chk("req_ready", 32'(req_ready), 32'(er));
          chk("idle_eng_start", 32'(eng_start), 32'd0);
          chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
          if (g >= 0) begin
            m_busy  = 1;
            m_id    = g;
            m_a     = req_a[32*g +: 32];
            m_b     = req_b[32*g +: 32];
            m_start = cyc + 1;
            m_byp   = (m_a[30:23] == 8'd0) || (m_b[30:23] == 8'd0);
            acc_k   = eng_k;
            if (m_byp) begin
              m_rsp = cyc + 2; m_data = {m_a[31] ^ m_b[31], 31'b0}; m_err = 0;
            end else if (acc_k >= 1 && acc_k <= TIMEOUT - 1) begin
              m_rsp = m_start + acc_k + 1; m_data = fmul(m_a, m_b); m_err = 0;
            end else begin
              m_rsp = m_start + TIMEOUT; m_data = 32'd0; m_err = 1;
            end
            acc_cnt++;
            acc_log.push_back(g);
            last_acc_cyc = cyc;
            last_acc_id  = g;
            acc_lat      = m_rsp - cyc;
            acc_data     = m_data;
            acc_err      = m_err;
          end
        end else begin
          bit es;
          chk("busy_req_ready", 32'(req_ready), 32'd0);
          es = !m_byp && (cyc == m_start);
          chk("eng_start", 32'(eng_start), 32'(es));
          if (es) begin
            chk("eng_a", eng_a, m_a);
            chk("eng_b", eng_b, m_b);
          end
          chk("rsp_valid", 32'(rsp_valid), 32'(cyc >= m_rsp));
          if (cyc >= m_rsp) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            if (rsp_ready) begin
              m_last = m_id;
              m_busy = 0;
              hs_cnt++;
              hs_cyc = cyc;
            end
          end
        end
        start_cnt += int'(eng_start);
      end
    end
  end

  // Engine stand-in: done pulse acc_k cycles after eng_start; a new start replaces a pending one.
  initial begin
    int          done_cyc;
    logic [31:0] res;
    done_cyc   = -1;
    res        = 32'd0;
    eng_done   = 1'b0;
    eng_result = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) done_cyc = -1;
      else if (eng_start) begin
        done_cyc = (acc_k > 0) ? cyc + acc_k : -1;
        res      = fmul(eng_a, eng_b);
      end
      @(posedge clk);
      #1;
      eng_done   = (cyc == done_cyc);
      eng_result = eng_done ? res : $urandom;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int budget);
    int s, n;
    s = acc_cnt;
    n = 0;
    while (acc_cnt == s && n < budget) begin
      step(1);
      n++;
    end
    chk("accept_seen", 32'(acc_cnt != s), 32'd1);
  endtask

  task automatic wait_hs(input int budget);
    int s, n;
    s = hs_cnt;
    n = 0;
    while (hs_cnt == s && n < budget) begin
      step(1);
      n++;
    end
    chk("handshake_seen", 32'(hs_cnt != s), 32'd1);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  initial begin
    int s0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_eng_a", eng_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Single request through the engine: 2.0 * 3.0
    eng_k = 25;
    s0 = start_cnt;
    set_op(1, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    wait_acc(10);
    req_valid = '0;
    wait_hs(100);
    chk("t1_latency", 32'(acc_lat), 32'd27);
    chk("t1_id", 32'(last_acc_id), 32'd1);
    chk("t1_data", acc_data, 32'h40C00000);
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);

    // All requesters valid from reset: grant order 0,1,2,3,0
    rst = 1'b1;
    eng_k = 3;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_op(), rand_op());
    req_valid = 4'hF;
    step(2);
    acc_log.delete();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) wait_acc(40);
    req_valid = '0;
    wait_hs(40);
    chk("t2_count", 32'(acc_log.size()), 32'd5);
    if (acc_log.size() >= 5) begin
      chk("t2_g0", 32'(acc_log[0]), 32'd0);
      chk("t2_g1", 32'(acc_log[1]), 32'd1);
      chk("t2_g2", 32'(acc_log[2]), 32'd2);
      chk("t2_g3", 32'(acc_log[3]), 32'd3);
      chk("t2_g4", 32'(acc_log[4]), 32'd0);
    end

    // Bypass: -0.0 * 1.0
    s0 = start_cnt;
    set_op(3, 32'h80000000, 32'h3F800000);
    req_valid = 4'b1000;
    wait_acc(10);
    req_valid = '0;
    wait_hs(20);
    chk("t3_latency", 32'(acc_lat), 32'd2);
    chk("t3_data", acc_data, 32'h80000000);
    chk("t3_err", 32'(acc_err), 32'd0);
    chk("t3_starts", 32'(start_cnt - s0), 32'd0);

    // Timeout, then a late done lands in IDLE while the next request is accepted
    eng_k = TIMEOUT + 1;
    set_op(0, 32'h3FC00000, 32'h3FC00000);
    req_valid = 4'b0001;
    wait_acc(10);
    req_valid = '0;
    wait_hs(100);
    chk("t4_latency", 32'(acc_lat), 32'd65);
    chk("t4_err", 32'(acc_err), 32'd1);
    chk("t4_data", acc_data, 32'd0);
    eng_k = 10;
    req_valid = 4'b0001;
    wait_acc(10);
    req_valid = '0;
    wait_hs(40);
    chk("t4b_data", acc_data, 32'h40100000);
    chk("t4b_err", 32'(acc_err), 32'd0);
    chk("t4b_latency", 32'(acc_lat), 32'd12);

    // Backpressure with requesters 2 and 3 waiting
    rsp_ready = 1'b0;
    eng_k = 5;
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, rand_op(), rand_op());
    set_op(3, rand_op(), rand_op());
    req_valid = 4'b0010;
    wait_acc(10);
    req_valid = 4'b1100;
    step(6 + 10);
    rsp_ready = 1'b1;
    wait_hs(5);
    wait_acc(5);
    chk("t5_accept_cycle", 32'(last_acc_cyc - hs_cyc), 32'd1);
    chk("t5_accept_id", 32'(last_acc_id), 32'd2);
    req_valid = 4'b1000;
    wait_acc(100);
    req_valid = '0;
    wait_hs(100);

    // Reset during WAIT
    eng_k = 25;
    set_op(2, 32'h40000000, 32'h40400000);
    req_valid = 4'b0100;
    wait_acc(10);
    req_valid = '0;
    step(4);
    rst = 1'b1;
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0101;
    step(1);
    @(negedge clk);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_eng_start", 32'(eng_start), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_eng_a", eng_a, 32'd0);
    chk("t6_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_acc(10);
    chk("t6_first_id", 32'(last_acc_id), 32'd0);
    req_valid = '0;
    wait_hs(100);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      int r;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 7) == 0) set_op(i, rand_op(), rand_op());
      r = $urandom_range(0, 19);
      if (r == 0) eng_k = TIMEOUT + 3;
      else if (r == 1) eng_k = TIMEOUT - 1;
      else if (r == 2) eng_k = TIMEOUT;
      else eng_k = $urandom_range(1, 12);
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step(TIMEOUT + 10);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
